// File: rtl/shift_register_load_controller.sv
// Loads a parallel word into an external serial-in shift register MSB first, then enforces an idle gap.
// Optional macro SHIFT_CTRL_PARITY_EN adds a word_parity output registered at capture.
module shift_register_load_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  abort,
   output logic                  shift_en,
   output logic                  shift_bit,
   output logic                  busy,
   output logic                  word_valid,
`ifdef SHIFT_CTRL_PARITY_EN
   output logic                  word_parity,
`endif
   output logic [7:0]            frame_cnt
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

   state_t                state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] hold;
   logic [3:0]            gap_cnt;

   // Outputs are computed for the next state so every one of them leaves a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         bit_cnt    <= CNT_W'(DATA_WIDTH - 1);
         hold       <= '0;
         gap_cnt    <= '0;
         in_ready   <= 1'b1;
         shift_en   <= 1'b0;
         shift_bit  <= 1'b0;
         busy       <= 1'b0;
         word_valid <= 1'b0;
         frame_cnt  <= 8'd0;
`ifdef SHIFT_CTRL_PARITY_EN
         word_parity <= 1'b0;
`endif
      end else begin
         shift_en   <= 1'b0;
         shift_bit  <= 1'b0;
         word_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  hold      <= in_data;
                  bit_cnt   <= CNT_W'(DATA_WIDTH - 1);
                  state     <= SHIFT;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  shift_en  <= 1'b1;
                  shift_bit <= in_data[DATA_WIDTH-1];
`ifdef SHIFT_CTRL_PARITY_EN
                  word_parity <= ^in_data;
`endif
               end
            end
            SHIFT: begin
               // An abort lets the current bit shift but drops the rest of the word.
               if (abort) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end else if (bit_cnt == '0) begin
                  state      <= DONE;
                  word_valid <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
               end else begin
                  bit_cnt   <= bit_cnt - 1'b1;
                  shift_en  <= 1'b1;
                  shift_bit <= hold[bit_cnt - 1'b1];
               end
            end
            DONE: begin
               if (GAP_CYCLES > 0) begin
                  state   <= GAP;
                  gap_cnt <= 4'(GAP_CYCLES - 1);
               end else begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            GAP: begin
               // The acceptance cycle in IDLE counts as the last gap cycle.
               if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
               if (gap_cnt <= 4'd1) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
